// File: rtl/tone_pkg.sv
// Shared definitions for the melody path: pitch codes, note frequencies,
// half-period table builder, sequencer states and the default song.
package tone_pkg;

  localparam int HP_W      = 22;
  localparam int NUM_PITCH = 16;
  localparam int ENTRY_W   = 8;

  localparam logic [3:0] P_REST = 4'd0;
  localparam logic [3:0] P_C4   = 4'd1;
  localparam logic [3:0] P_CS4  = 4'd2;
  localparam logic [3:0] P_D4   = 4'd3;
  localparam logic [3:0] P_DS4  = 4'd4;
  localparam logic [3:0] P_E4   = 4'd5;
  localparam logic [3:0] P_F4   = 4'd6;
  localparam logic [3:0] P_FS4  = 4'd7;
  localparam logic [3:0] P_G4   = 4'd8;
  localparam logic [3:0] P_GS4  = 4'd9;
  localparam logic [3:0] P_A4   = 4'd10;
  localparam logic [3:0] P_AS4  = 4'd11;
  localparam logic [3:0] P_B4   = 4'd12;
  localparam logic [3:0] P_C5   = 4'd13;
  localparam logic [3:0] P_D5   = 4'd14;
  localparam logic [3:0] P_E5   = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    GAP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] pitch;
    logic [3:0] dur;
  } song_entry_t;

  // Equal-tempered note frequencies in millihertz, indexed by pitch code.
  localparam longint PITCH_MHZ [NUM_PITCH] = '{
    64'd0,
    64'd261626, 64'd277183, 64'd293665, 64'd311127,
    64'd329628, 64'd349228, 64'd369994, 64'd391995,
    64'd415305, 64'd440000, 64'd466164, 64'd493883,
    64'd523251, 64'd587330, 64'd659255
  };

  // half = round(clk / (2 f)) - 1, evaluated once at elaboration.
  function automatic logic [NUM_PITCH*HP_W-1:0] build_hp_table(input longint clk_hz);
    logic [NUM_PITCH*HP_W-1:0] tab;
    longint hp;
    tab = '0;
    for (int i = 1; i < NUM_PITCH; i++) begin
      hp = (clk_hz * 64'd1000 + PITCH_MHZ[i]) / (64'd2 * PITCH_MHZ[i]) - 64'd1;
      tab[i*HP_W +: HP_W] = hp[HP_W-1:0];
    end
    return tab;
  endfunction

  localparam int DEFAULT_LEN = 16;

  // Entry 15 is the leftmost byte; the song ends on the marker in entry 15.
  localparam logic [DEFAULT_LEN*ENTRY_W-1:0] DEFAULT_SONG = {
    P_REST, 4'd0,  P_REST, 4'd2,  P_C4, 4'd4,  P_E4, 4'd2,
    P_F4,   4'd2,  P_G4,   4'd2,  P_A4, 4'd2,  P_G4, 4'd2,
    P_REST, 4'd1,  P_G4,   4'd4,  P_F4, 4'd2,  P_E4, 4'd2,
    P_C4,   4'd2,  P_E4,   4'd2,  P_D4, 4'd2,  P_C4, 4'd2
  };

endpackage

// File: rtl/note_sequencer_if.sv
// Control and tone-output bundle between a playback controller and the sequencer.
interface note_sequencer_if;

  // start/stop/loop_en are sampled on every rising clk edge with no ready
  // back-pressure; done is a one-cycle pulse, counter/mute/playing are levels.
  logic                     start;
  logic                     stop;
  logic                     loop_en;
  logic [tone_pkg::HP_W-1:0] counter;
  logic                     mute;
  logic                     playing;
  logic                     done;

  modport master (
    output start,
    output stop,
    output loop_en,
    input  counter,
    input  mute,
    input  playing,
    input  done
  );

  modport slave (
    input  start,
    input  stop,
    input  loop_en,
    output counter,
    output mute,
    output playing,
    output done
  );

endinterface

// File: rtl/pitch_rom.sv
// Combinational pitch code to half-period lookup for the tone generator.
module pitch_rom
  import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic [3:0]      code,
    output logic [HP_W-1:0] half_period
);

    localparam logic [NUM_PITCH*HP_W-1:0] HP_TABLE = build_hp_table(longint'(CLK_HZ));

    logic [HP_W-1:0] hp_tab [NUM_PITCH];

    for (genvar i = 0; i < NUM_PITCH; i++) begin : g_tab
        assign hp_tab[i] = HP_TABLE[i*HP_W +: HP_W];
    end

    assign half_period = hp_tab[code];

endmodule

// File: rtl/note_sequencer.sv
// Steps through a song ROM, presenting each note's half-period to the tone
// generator for its duration, followed by a muted gap.
module note_sequencer
  import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned TICK_DIV = 12_500_000,
    parameter int unsigned GAP_CYC  = 1_000_000,
    parameter int unsigned SONG_LEN = 16,
    parameter logic [SONG_LEN*ENTRY_W-1:0] SONG_ROM = DEFAULT_SONG
) (
    input  logic                        clk,
    input  logic                        rst,
    note_sequencer_if.slave             bus,
    output state_e                      dbg_state,
    output logic [$clog2(SONG_LEN)-1:0] dbg_addr
);

    localparam int AW = $clog2(SONG_LEN);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(SONG_LEN - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [3:0]      dur_q, dur_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [HP_W-1:0] counter_q, counter_d;
    logic            rest_q, rest_d;
    logic            done_q, done_d;
    logic            song_end;

    song_entry_t     song_rom [SONG_LEN];
    song_entry_t     entry;
    logic [HP_W-1:0] lookup_hp;

    for (genvar i = 0; i < SONG_LEN; i++) begin : g_rom
        assign song_rom[i] = song_entry_t'(SONG_ROM[i*ENTRY_W +: ENTRY_W]);
    end

    assign entry = song_rom[addr_q];

    pitch_rom #(
        .CLK_HZ(CLK_HZ)
    ) u_pitch_rom (
        .code       (entry.pitch),
        .half_period(lookup_hp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            tick_q    <= '0;
            dur_q     <= '0;
            gap_q     <= '0;
            counter_q <= '0;
            rest_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            tick_q    <= tick_d;
            dur_q     <= dur_d;
            gap_q     <= gap_d;
            counter_q <= counter_d;
            rest_q    <= rest_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tick_d    = tick_q;
        dur_d     = dur_q;
        gap_d     = gap_q;
        counter_d = counter_q;
        rest_d    = rest_q;
        done_d    = 1'b0;
        song_end  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    addr_d  = '0;
                end
            end
            LOAD: begin
                if (entry.dur == 4'd0) begin
                    song_end = 1'b1;
                end else begin
                    state_d = PLAY;
                    dur_d   = entry.dur;
                    tick_d  = '0;
                    rest_d  = (entry.pitch == P_REST);
                    // A rest leaves the generator on its previous pitch; mute silences it.
                    if (entry.pitch != P_REST) begin
                        counter_d = lookup_hp;
                    end
                end
            end
            PLAY: begin
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    dur_d  = dur_q - 4'd1;
                    if (dur_q == 4'd1) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    addr_d = addr_q + 1'b1;
                    if (addr_q == ADDR_LAST) begin
                        song_end = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (song_end) begin
            if (bus.loop_en) begin
                state_d = LOAD;
                addr_d  = '0;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end

        // Stop wins over everything and must not disturb the presented pitch.
        if (bus.stop) begin
            state_d   = IDLE;
            addr_d    = addr_q;
            counter_d = counter_q;
            rest_d    = rest_q;
            done_d    = 1'b0;
        end
    end

    assign bus.counter = counter_q;
    assign bus.mute    = (state_q != PLAY) || rest_q;
    assign bus.playing = (state_q != IDLE);
    assign bus.done    = done_q;
    assign dbg_state   = state_q;
    assign dbg_addr    = addr_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed-vector bench for note_sequencer with a short tick/gap configuration.
module tb_note_sequencer;
  import tone_pkg::*;

  localparam int A4 = 113635;
  localparam int C4 = 191112;
  localparam int C5 = 95555;

  // Song A: {A4,2}, {rest,1}, {E4,0 = end marker}, then markers.
  localparam logic [127:0] SONG_A = {104'h0, 8'h50, 8'h01, 8'hA2};
  // Song B: 16 entries, no marker: {C4,1}, 14 x {rest,1}, {C5,1}.
  localparam logic [127:0] SONG_B = {8'hD1, {14{8'h01}}, 8'h11};

  typedef struct {
    logic   start;
    logic   stop;
    logic   loop_en;
    state_e st;
    int     addr;
    int     counter;
    logic   mute;
    logic   playing;
    logic   done;
  } vec_t;

  logic clk;
  logic rst;
  state_e     dbg_state_a, dbg_state_b;
  logic [3:0] dbg_addr_a, dbg_addr_b;

  note_sequencer_if bus_a ();
  note_sequencer_if bus_b ();

  note_sequencer #(
    .CLK_HZ(100_000_000), .TICK_DIV(4), .GAP_CYC(2), .SONG_LEN(16), .SONG_ROM(SONG_A)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .dbg_state(dbg_state_a), .dbg_addr(dbg_addr_a)
  );

  note_sequencer #(
    .CLK_HZ(100_000_000), .TICK_DIV(4), .GAP_CYC(2), .SONG_LEN(16), .SONG_ROM(SONG_B)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .dbg_state(dbg_state_b), .dbg_addr(dbg_addr_b)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  logic [21:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic s, input logic p, input logic l, input state_e st,
                         input int a, input int c, input logic m, input logic pl,
                         input logic d, input int n);
    vec_t v;
    v.start = s; v.stop = p; v.loop_en = l; v.st = st; v.addr = a;
    v.counter = c; v.mute = m; v.playing = pl; v.done = d;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic check_a(input string tag, input state_e st, input int a, input int c,
                         input logic m, input logic pl, input logic d);
    check({tag, " state"}, 64'(dbg_state_a), 64'(st));
    check({tag, " addr"}, 64'(dbg_addr_a), 64'(a));
    check({tag, " counter"}, 64'(bus_a.counter), 64'(c));
    check({tag, " mute"}, 64'(bus_a.mute), 64'(m));
    check({tag, " playing"}, 64'(bus_a.playing), 64'(pl));
    check({tag, " done"}, 64'(bus_a.done), 64'(d));
  endtask

  // ---------------- driver: one vector per clock ----------------
  task automatic apply_vec(input int idx, input vec_t v);
    bus_a.start   = v.start;
    bus_a.stop    = v.stop;
    bus_a.loop_en = v.loop_en;
    @(posedge clk);
    @(negedge clk);
    check_a($sformatf("r%0d", idx), v.st, v.addr, v.counter, v.mute, v.playing, v.done);
  endtask

  initial begin
    logic [21:0] exp_hp;
    logic        done_seen;

    rst = 1'b1;
    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.loop_en = 1'b0;
    bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.loop_en = 1'b0;

    // Song A, no loop: note, rest, end marker, done pulse.
    add_vec(1, 0, 0, LOAD, 0, 0,  1, 1, 0, 1);
    add_vec(0, 0, 0, PLAY, 0, A4, 0, 1, 0, 8);
    add_vec(0, 0, 0, GAP,  0, A4, 1, 1, 0, 2);
    add_vec(0, 0, 0, LOAD, 1, A4, 1, 1, 0, 1);
    add_vec(0, 0, 0, PLAY, 1, A4, 1, 1, 0, 4);
    add_vec(0, 0, 0, GAP,  1, A4, 1, 1, 0, 2);
    add_vec(0, 0, 0, LOAD, 2, A4, 1, 1, 0, 1);
    add_vec(0, 0, 0, IDLE, 2, A4, 1, 0, 1, 1);
    add_vec(0, 0, 0, IDLE, 2, A4, 1, 0, 0, 2);
    // Song A looping, then stop together with start mid-PLAY.
    add_vec(1, 0, 1, LOAD, 0, A4, 1, 1, 0, 1);
    add_vec(0, 0, 1, PLAY, 0, A4, 0, 1, 0, 8);
    add_vec(0, 0, 1, GAP,  0, A4, 1, 1, 0, 2);
    add_vec(0, 0, 1, LOAD, 1, A4, 1, 1, 0, 1);
    add_vec(0, 0, 1, PLAY, 1, A4, 1, 1, 0, 4);
    add_vec(0, 0, 1, GAP,  1, A4, 1, 1, 0, 2);
    add_vec(0, 0, 1, LOAD, 2, A4, 1, 1, 0, 1);
    add_vec(0, 0, 1, LOAD, 0, A4, 1, 1, 0, 1);
    add_vec(0, 0, 1, PLAY, 0, A4, 0, 1, 0, 3);
    add_vec(1, 1, 1, IDLE, 0, A4, 1, 0, 0, 1);
    add_vec(0, 0, 0, IDLE, 0, A4, 1, 0, 0, 1);
    // Start ignored in GAP; stop on a rest; stop beats start in IDLE; restart.
    add_vec(1, 0, 0, LOAD, 0, A4, 1, 1, 0, 1);
    add_vec(0, 0, 0, PLAY, 0, A4, 0, 1, 0, 8);
    add_vec(0, 0, 0, GAP,  0, A4, 1, 1, 0, 1);
    add_vec(1, 0, 0, GAP,  0, A4, 1, 1, 0, 1);
    add_vec(1, 0, 0, LOAD, 1, A4, 1, 1, 0, 1);
    add_vec(0, 0, 0, PLAY, 1, A4, 1, 1, 0, 2);
    add_vec(1, 1, 0, IDLE, 1, A4, 1, 0, 0, 1);
    add_vec(1, 1, 0, IDLE, 1, A4, 1, 0, 0, 1);
    add_vec(1, 0, 0, LOAD, 0, A4, 1, 1, 0, 1);
    add_vec(0, 0, 0, PLAY, 0, A4, 0, 1, 0, 3);

    exp_q.push_back(22'(C4));
    exp_q.push_back(22'(C5));
    exp_q.push_back(22'(C4));

    // Reset state of both instances.
    @(negedge clk);
    @(negedge clk);
    check_a("reset", IDLE, 0, 0, 1, 0, 0);
    check("reset b counter", 64'(bus_b.counter), 64'd0);
    check("reset b mute", 64'(bus_b.mute), 64'd1);
    check("reset b playing", 64'(bus_b.playing), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) apply_vec(i, vecs[i]);

    // Asynchronous reset mid-PLAY: outputs return before the next edge.
    #2 rst = 1'b1;
    #1;
    check_a("async rst", IDLE, 0, 0, 1, 0, 0);
    @(negedge clk);
    bus_a.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_a("post rst", IDLE, 0, 0, 1, 0, 0);

    // Song B: full 16 entries, wrap 15 -> 0 with loop, then natural end.
    done_seen = 1'b0;
    bus_b.loop_en = 1'b1;
    bus_b.start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_b.start = 1'b0;
    check("b start state", 64'(dbg_state_b), 64'(LOAD));
    for (int cyc = 2; cyc <= 226; cyc++) begin
      bus_b.loop_en = (cyc <= 114);
      @(posedge clk);
      @(negedge clk);
      if (cyc <= 114) done_seen = done_seen | bus_b.done;
      if (cyc == 5 || cyc == 108 || cyc == 114) begin
        exp_hp = exp_q.pop_front();
        check($sformatf("b c%0d state", cyc), 64'(dbg_state_b), 64'(PLAY));
        check($sformatf("b c%0d counter", cyc), 64'(bus_b.counter), 64'(exp_hp));
        check($sformatf("b c%0d mute", cyc), 64'(bus_b.mute), 64'd0);
        check($sformatf("b c%0d addr", cyc), 64'(dbg_addr_b), (cyc == 108) ? 64'd15 : 64'd0);
      end
      if (cyc == 113) begin
        check("b wrap state", 64'(dbg_state_b), 64'(LOAD));
        check("b wrap addr", 64'(dbg_addr_b), 64'd0);
      end
      if (cyc == 114) check("b loop no done", 64'(done_seen), 64'd0);
      if (cyc == 225) begin
        check("b end state", 64'(dbg_state_b), 64'(IDLE));
        check("b end done", 64'(bus_b.done), 64'd1);
        check("b end playing", 64'(bus_b.playing), 64'd0);
      end
      if (cyc == 226) check("b done pulse width", 64'(bus_b.done), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
